// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory controller.
//   state_t    - controller state (EMPTY after reset, LOADING, READY)
//   NOP        - word returned on faulted fetches
//   cnt_width  - width of load_count for a given depth (must hold 0..DEPTH)
// Optional feature macro used by the controller: IMEM_PARITY_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // load_count must represent DEPTH itself, hence the extra bit
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// imem_resp_pipe: STAGES-deep register pipe carrying a fetch response.
//   clk, reset            - clock, async active-high reset
//   acc_valid/fault/data  - response formed in the acceptance cycle
//   rsp_valid/fault/data  - same response, STAGES cycles later
// Every stage is cleared on reset so in-flight responses are discarded
// and the outputs sit at zero until the first real response.
module imem_resp_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         acc_valid,
  input  logic         acc_fault,
  input  logic [W-1:0] acc_data,
  output logic         rsp_valid,
  output logic         rsp_fault,
  output logic [W-1:0] rsp_data
);

  logic [STAGES:1]        vld_pipe;
  logic [STAGES:1]        flt_pipe;
  logic [STAGES:1][W-1:0] dat_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      flt_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc_valid;
      flt_pipe[1] <= acc_fault;
      dat_pipe[1] <= acc_data;
      for (int i = STAGES; i > 1; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        flt_pipe[i] <= flt_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign rsp_valid = vld_pipe[STAGES];
  assign rsp_fault = flt_pipe[STAGES];
  assign rsp_data  = dat_pipe[STAGES];

endmodule

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with sequential program load and a
// fixed-latency fetch port with alignment/range fault detection.
//   clk, reset         - clock, async active-high reset
//   load_start         - pulse: (re)start loading at word 0
//   load_valid/data    - one program word per valid cycle
//   load_last          - final word of the program
//   load_busy          - a load is in progress
//   load_count         - words written by the last completed load
//   fetch_req/addr     - fetch request (byte address)
//   fetch_ready        - request accepted when fetch_req && fetch_ready
//   instr_valid        - response pulse, READ_LAT cycles after acceptance
//   instruction        - fetched word (NOP when faulted by address)
//   fetch_fault        - misaligned, out of range, or parity error
// Macro IMEM_PARITY_EN: adds a stored even-parity bit per word, checked on
// read, and the parity_inject input that corrupts it on a load write.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,  // at most 2^(ADDR_W-2)
  parameter int READ_LAT = 1     // 1..4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         load_last,
`ifdef IMEM_PARITY_EN
  input  logic                         parity_inject,
`endif
  output logic                         load_busy,
  output logic [cnt_width(DEPTH)-1:0]  load_count,
  input  logic                         fetch_req,
  input  logic [ADDR_W-1:0]            fetch_addr,
  output logic                         fetch_ready,
  output logic                         instr_valid,
  output logic [DATA_W-1:0]            instruction,
  output logic                         fetch_fault
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = ADDR_W - 2;

  // ---------------- load FSM ----------------
  state_t           state, state_nx;
  logic [PTR_W-1:0] ptr, ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    wr_en    = 1'b0;
    // load_start wins over a same-cycle load_valid, including a restart
    if (load_start) begin
      state_nx = LOADING;
      ptr_nx   = '0;
    end else if (state == LOADING && load_valid) begin
      wr_en = 1'b1;
      if (load_last || ptr == PTR_W'(DEPTH - 1)) begin
        state_nx = READY;
        ptr_nx   = '0;
        cnt_nx   = CNT_W'(ptr) + CNT_W'(1);
      end else begin
        ptr_nx = ptr + PTR_W'(1);
      end
    end
  end

  assign load_busy   = (state == LOADING);
  assign fetch_ready = (state == READY);
  assign load_count  = cnt;

  // ---------------- storage (never reset) ----------------
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= load_data;
  end

  // ---------------- fetch path ----------------
  logic [IDX_W-1:0]  idx;
  logic [PTR_W-1:0]  rd_idx;
  logic              misal, oor, addr_bad, par_err, accept;
  logic [DATA_W-1:0] rd_word;

  assign idx      = fetch_addr[ADDR_W-1:2];
  assign misal    = |fetch_addr[1:0];
  assign oor      = 32'(idx) >= DEPTH;
  assign addr_bad = misal | oor;
  // rd_idx may alias a valid word when out of range; addr_bad masks it
  assign rd_idx   = idx[PTR_W-1:0];
  assign rd_word  = mem[rd_idx];
  assign accept   = fetch_req & fetch_ready;

`ifdef IMEM_PARITY_EN
  logic mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_par[ptr] <= (^load_data) ^ parity_inject;
  end

  // parity errors are only meaningful on an addressable word
  assign par_err = ~addr_bad & ((^rd_word) != mem_par[rd_idx]);
`else
  assign par_err = 1'b0;
`endif

  imem_resp_pipe #(
    .W      (DATA_W),
    .STAGES (READ_LAT)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .acc_valid (accept),
    .acc_fault (addr_bad | par_err),
    .acc_data  (addr_bad ? DATA_W'(NOP) : rd_word),
    .rsp_valid (instr_valid),
    .rsp_fault (fetch_fault),
    .rsp_data  (instruction)
  );

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: self-checking bench for instr_mem_ctrl (DEPTH=256,
// READ_LAT=3). A transaction-level model (state, word array, queue of due
// responses) predicts every output each cycle; a vector table and a few
// hand-written sequences cover the corner cases.
module tb_instr_mem_ctrl;
  localparam int DATA_W = 32, ADDR_W = 16, DEPTH = 256, READ_LAT = 3;

  logic              clk = 1'b0;
  logic              reset, load_start, load_valid, load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_busy;
  logic [8:0]        load_count;
  logic              fetch_req, fetch_ready, instr_valid, fetch_fault;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instruction;
`ifdef IMEM_PARITY_EN
  logic              parity_inject;
`endif

  instr_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
`ifdef IMEM_PARITY_EN
    .parity_inject(parity_inject),
`endif
    .load_busy(load_busy), .load_count(load_count), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_ready(fetch_ready), .instr_valid(instr_valid),
    .instruction(instruction), .fetch_fault(fetch_fault));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; bit fault; bit chk_data; logic [31:0] data; } rsp_t;
  int          m_state = 0;  // 0 empty, 1 loading, 2 ready
  int          m_ptr = 0, m_cnt = 0, cyc_n = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  bit          m_pbad[DEPTH];
  rsp_t        rq[$];
  rsp_t        got[$];

  task automatic model_edge();
    int idx; bit bad; rsp_t r;
    if (reset) begin
      m_state = 0; m_ptr = 0; m_cnt = 0; rq.delete();
    end else begin
      if (fetch_req && m_state == 2) begin
        idx = int'(fetch_addr) / 4;
        bad = (fetch_addr % 4 != 0) || idx >= DEPTH;
        r.due = cyc_n + READ_LAT;
        r.fault = bad || m_pbad[idx % DEPTH];
        r.data = bad ? 32'h0 : m_mem[idx];
        r.chk_data = bad || m_wr[idx];
        rq.push_back(r);
      end
      if (load_start) begin
        m_state = 1; m_ptr = 0;
      end else if (m_state == 1 && load_valid) begin
        m_mem[m_ptr] = load_data;
        m_wr[m_ptr] = 1'b1;
`ifdef IMEM_PARITY_EN
        m_pbad[m_ptr] = parity_inject;
`endif
        m_ptr++;
        if (load_last || m_ptr == DEPTH) begin m_state = 2; m_cnt = m_ptr; end
      end
    end
    cyc_n++;
  endtask

  task automatic check_outputs();
    rsp_t r;
    chk("fetch_ready", fetch_ready, m_state == 2);
    chk("load_busy", load_busy, m_state == 1);
    chk("load_count", load_count, m_cnt);
    if (reset) begin
      chk("rst_instr", instruction, 0);
      chk("rst_fault", fetch_fault, 0);
    end
    if (rq.size() > 0 && rq[0].due == cyc_n) begin
      r = rq.pop_front();
      chk("instr_valid", instr_valid, 1);
      chk("fetch_fault", fetch_fault, r.fault);
      if (r.chk_data) chk("instruction", instruction, r.data);
      r.data = instruction; r.fault = fetch_fault;
      got.push_back(r);
    end else begin
      chk("instr_valid_idle", instr_valid, 0);
    end
  endtask

  // one clock: inputs already driven; model on the edge, check on negedge
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  logic [31:0] prog[$];

  task automatic load_prog(input bit use_last);
    load_start = 1; load_valid = 1; load_data = 32'hDEAD_BEEF; // ignored word
    cyc();
    load_start = 0;
    for (int i = 0; i < prog.size(); i++) begin
      load_valid = 1; load_data = prog[i];
      load_last = use_last && (i == prog.size() - 1);
      cyc();
    end
    load_valid = 0; load_last = 0;
  endtask

  typedef struct { logic [15:0] addr; bit fault; logic [31:0] data; } vec_t;
  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_wr[i] = 0; m_pbad[i] = 0; end
    tbl[0] = '{16'h0000, 1'b0, 32'h2008_0005};
    tbl[1] = '{16'h0004, 1'b0, 32'h2009_0007};
    tbl[2] = '{16'h0008, 1'b0, 32'h0109_5020};
    tbl[3] = '{16'h0006, 1'b1, 32'h0000_0000};
    tbl[4] = '{16'h0400, 1'b1, 32'h0000_0000};
    tbl[5] = '{16'h0002, 1'b1, 32'h0000_0000};

    reset = 1; load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
    fetch_req = 0; fetch_addr = 0;
`ifdef IMEM_PARITY_EN
    parity_inject = 0;
`endif
    idle(2);
    reset = 0;

    // fetch while EMPTY is never accepted
    fetch_req = 1; fetch_addr = 16'h0000;
    idle(6);
    fetch_req = 0;

    // 3-word program, load_last on the third
    prog = '{32'h2008_0005, 32'h2009_0007, 32'h0109_5020};
    load_prog(1);
    chk("cnt3", load_count, 3);
    chk("ready_after3", fetch_ready, 1);

    // table: back-to-back fetches, then compare responses in order
    got.delete();
    for (int i = 0; i < 6; i++) begin
      fetch_req = 1; fetch_addr = tbl[i].addr; cyc();
    end
    fetch_req = 0;
    idle(READ_LAT + 1);
    chk("tbl_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      chk($sformatf("tbl%0d_fault", i), got[i].fault, tbl[i].fault);
      chk($sformatf("tbl%0d_data", i), got[i].data, tbl[i].data);
    end

    // full-depth load without load_last: auto-finish at word 255
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    load_start = 1; cyc(); load_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1; load_data = prog[i]; cyc();
    end
    load_valid = 0;
    chk("cnt256", load_count, 256);

    // random fetch traffic: aligned, misaligned, out of range
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      fetch_req = ($urandom_range(0, 3) != 0);
      if (sel < 7)      fetch_addr = 16'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 9) fetch_addr = 16'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else              fetch_addr = 16'($urandom_range(DEPTH, 16383) * 4);
      cyc();
    end
    fetch_req = 0;
    idle(READ_LAT + 1);

    // fetches in flight when load_start arrives still complete;
    // restart mid-load keeps load_count until the new load finishes
    fetch_req = 1; fetch_addr = 16'h0010; cyc();
    fetch_addr = 16'h0014; load_start = 1; cyc();
    load_start = 0; fetch_req = 0;
    for (int i = 0; i < 10; i++) begin load_valid = 1; load_data = $urandom; cyc(); end
    chk("cnt_kept", load_count, 256);
    load_valid = 0;
    prog = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C, 32'h5555_0010};
    load_prog(1);
    chk("cnt5", load_count, 5);
    for (int i = 0; i < 12; i++) begin
      fetch_req = 1; fetch_addr = 16'(i * 4); cyc();
    end
    fetch_req = 0;
    idle(READ_LAT + 1);

    // reset with responses in flight: nothing emerges afterwards
    fetch_req = 1; fetch_addr = 16'h0000; cyc();
    fetch_addr = 16'h0004; cyc();
    fetch_req = 0; reset = 1; cyc();
    reset = 0;
    idle(READ_LAT + 2);
    chk("rst_cnt0", load_count, 0);

    // reset mid-load of a second program
    prog.delete();
    for (int i = 0; i < 20; i++) prog.push_back($urandom);
    load_start = 1; cyc(); load_start = 0;
    for (int i = 0; i < 8; i++) begin load_valid = 1; load_data = prog[i]; cyc(); end
    reset = 1; cyc();
    reset = 0; load_valid = 0;
    idle(4);
    chk("midload_busy", load_busy, 0);
    chk("midload_ready", fetch_ready, 0);

`ifdef IMEM_PARITY_EN
    // corrupted parity on word 0: fault with stored data returned
    load_start = 1; cyc(); load_start = 0;
    load_valid = 1; load_data = 32'h1234_5678; parity_inject = 1; cyc();
    load_data = 32'h0BAD_F00D; parity_inject = 0; load_last = 1; cyc();
    load_valid = 0; load_last = 0;
    got.delete();
    fetch_req = 1; fetch_addr = 16'h0000; cyc();
    fetch_addr = 16'h0004; cyc();
    fetch_req = 0;
    idle(READ_LAT + 1);
    chk("par_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("par_fault", got[0].fault, 1);
      chk("par_data", got[0].data, 32'h1234_5678);
      chk("par_ok_fault", got[1].fault, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory with a sequential program-load port, a fetch request/response interface with configurable read latency, and alignment/range fault detection. Sits between the program loader (testbench or boot logic) and the fetch stage of the MIPS datapath. Accepts one fetch per cycle once a program is loaded and returns the instruction word a fixed number of cycles later.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 16, fetch byte-address width
- DEPTH, 256, number of instruction words (at most 2^(ADDR_W-2))
- READ_LAT, 1, fetch-to-response latency in cycles, legal range 1..4

Ports; reset is asynchronous, active-high:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- load_start  input  1  pulse: begin loading at word 0
- load_valid  input  1  load_data is valid this cycle
- load_data  input  DATA_W  word to write at the load pointer
- load_last  input  1  qualifies load_valid: final word of the program
- load_busy  output  1  state is LOADING
- load_count  output  clog2(DEPTH)+1  words written by the last completed load
- fetch_req  input  1  fetch request
- fetch_addr  input  ADDR_W  byte address
- fetch_ready  output  1  request accepted when fetch_req && fetch_ready
- instr_valid  output  1  response valid, one-cycle pulse per request
- instruction  output  DATA_W  fetched word
- fetch_fault  output  1  response is faulted (misaligned or out of range)

## Operation
- States: EMPTY (reset), LOADING, READY. fetch_ready = 1 only in READY.
- EMPTY/READY + load_start -> LOADING, pointer = 0. A load_valid in the same cycle as load_start is ignored.
- LOADING + load_valid: mem[ptr] <= load_data, ptr++. If load_last, or ptr == DEPTH-1: -> READY, load_count = ptr+1 (so 1..DEPTH).
- load_start while LOADING restarts at pointer 0; load_count is left unchanged.
- Word index = fetch_addr[ADDR_W-1:2]. Misaligned means fetch_addr[1:0] != 0. Out of range means index >= DEPTH.
- Faulted request: instruction = 0x00000000 (NOP), fetch_fault = 1. Otherwise instruction = mem[index], fetch_fault = 0.
- Locations not written since power-up read as X. The array is never reset.
- Requests already accepted when load_start arrives still complete with the data read at acceptance.

## Timing
- Array is read in the acceptance cycle; the result goes through a READ_LAT-deep register pipe.
- instr_valid rises exactly READ_LAT cycles after acceptance. Throughput is one request per cycle, with no bubbles.
- fetch_ready falls on the cycle after load_start is sampled. It rises on the cycle after the final load write.
- A fetch to a word written in the same cycle cannot occur, because fetches are blocked while LOADING.
- Reset values: state EMPTY, pointer 0, load_busy 0, load_count 0, fetch_ready 0, instr_valid 0, instruction 0, fetch_fault 0, all pipe valid bits 0.
- Reset during LOADING or with responses in flight discards them: no instr_valid after reset deasserts.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on write.
  - The read path recomputes parity; a mismatch sets fetch_fault on that response, and instruction still carries the stored data.
  - A port parity_inject (input, 1) flips the stored parity bit of the current load write, for test.
- IMEM_PARITY_EN undefined: no parity storage, no parity_inject port. Faults come only from address checks.

## Structure
- Package imem_pkg holds:
  - the state enum (EMPTY, LOADING, READY)
  - the NOP constant 32'h00000000
  - the function computing load_count width
- Sub-module imem_resp_pipe: parametrised READ_LAT-stage shift register carrying {valid, fault, data}, with asynchronous reset on the valid bits.

## Test plan
- Reset, then fetch_req=1 at 0x0000 -> fetch_ready=0, instr_valid never asserts, state EMPTY.
- load_start, then 3 words 0x20080005, 0x20090007, 0x01095020 with load_last on the third -> load_count=3, fetch_ready=1 one cycle after the last write.
- READ_LAT=3, back-to-back fetches at 0x0, 0x4, 0x8 -> instr_valid high for 3 consecutive cycles starting 3 cycles after the first accept, data in order.
- Fetch 0x0006 -> NOP with fault. Fetch 0x0400 with DEPTH=256 -> NOP with fault.
- Load 256 words without load_last -> auto-finish at word 255, load_count=256. Assert reset mid-load of a second program -> EMPTY, load_count 0, no instr_valid.
- IMEM_PARITY_EN: load word 0 with parity_inject=1, then fetch 0x0 -> fetch_fault=1 and instruction equals the stored data.
